// File: rtl/rob_scheduler.sv
// Reorder buffer scheduler: allocates entries in program order, accepts
// out-of-order writebacks and retires completed entries in order from the head.
module rob_scheduler #(
   parameter int ID_SIZE          = 3,
   parameter int REG_ADDRESS_SIZE = 5,
   parameter int REGISTER_SIZE    = 32
) (
   input  logic                        clk,
   input  logic                        reset,
   input  logic                        alloc_valid,
   input  logic [REG_ADDRESS_SIZE-1:0] alloc_addr,
   input  logic                        alloc_we,
   output logic                        alloc_ready,
   output logic [ID_SIZE-1:0]          alloc_id,
   input  logic                        wb_valid,
   input  logic [ID_SIZE-1:0]          wb_id,
   input  logic [REGISTER_SIZE-1:0]    wb_value,
   output logic                        commit_valid,
   input  logic                        commit_ready,
   output logic [REG_ADDRESS_SIZE-1:0] commit_addr,
   output logic [REGISTER_SIZE-1:0]    commit_value,
   output logic                        commit_we,
   input  logic                        flush,
   output logic [ID_SIZE-1:0]          head,
   output logic [ID_SIZE-1:0]          tail,
   output logic [ID_SIZE:0]            count,
   output logic                        full,
   output logic                        empty
);

   localparam int                 DEPTH     = 2**ID_SIZE;
   localparam logic [ID_SIZE-1:0] ID_ONE    = 1;
   localparam logic [ID_SIZE:0]   CNT_ONE   = 1;
   localparam logic [ID_SIZE:0]   CNT_DEPTH = {1'b1, {ID_SIZE{1'b0}}};

   typedef enum logic {RUN, FLUSH} state_t;

   typedef struct packed {
      logic                        valid;
      logic                        done;
      logic [REG_ADDRESS_SIZE-1:0] addr;
      logic                        we;
      logic [REGISTER_SIZE-1:0]    value;
   } entry_t;

   entry_t             r_entry [DEPTH];
   state_t             r_state;
   state_t             w_state_next;
   logic [ID_SIZE-1:0] r_head;
   logic [ID_SIZE-1:0] r_tail;
   logic [ID_SIZE:0]   r_count;
   entry_t             w_head_entry;
   logic               w_alloc;
   logic               w_commit;
   logic               w_wb;

   assign w_head_entry = r_entry[r_head];
   assign full         = (r_count == CNT_DEPTH);
   assign empty        = (r_count == '0);

   // NOTE: every output of this block gets a default first, so no path can infer a latch.
   always_comb begin
      w_state_next = RUN;
      alloc_ready  = 1'b0;
      commit_valid = 1'b0;
      if (flush) begin
         w_state_next = FLUSH;
      end
      if (r_state == RUN) begin
         alloc_ready  = !full && !flush;
         commit_valid = w_head_entry.valid && w_head_entry.done;
      end
   end

   // Slot availability comes from registered count only; a commit frees nothing until the next cycle.
   assign w_alloc  = alloc_valid && alloc_ready;
   assign w_commit = commit_valid && commit_ready && !flush;
   assign w_wb     = wb_valid && r_entry[wb_id].valid && (r_state == RUN) && !flush;

   // NOTE: all state below uses non-blocking assignments so every register samples pre-edge values.
   always_ff @(posedge clk) begin
      if (reset) begin
         r_state <= RUN;
         r_head  <= '0;
         r_tail  <= '0;
         r_count <= '0;
         // NOTE: the entry array is reset in full because the commit fields must read zero after reset.
         for (int i = 0; i < DEPTH; i++) begin
            r_entry[i] <= '0;
         end
      end else if (flush) begin
         r_state <= w_state_next;
         r_head  <= '0;
         r_tail  <= '0;
         r_count <= '0;
         for (int i = 0; i < DEPTH; i++) begin
            r_entry[i].valid <= 1'b0;
            r_entry[i].done  <= 1'b0;
         end
      end else begin
         r_state <= w_state_next;
         if (w_alloc) begin
            r_entry[r_tail].valid <= 1'b1;
            r_entry[r_tail].done  <= 1'b0;
            r_entry[r_tail].addr  <= alloc_addr;
            r_entry[r_tail].we    <= alloc_we;
            r_tail                <= r_tail + ID_ONE;
         end
         if (w_wb) begin
            r_entry[wb_id].done  <= 1'b1;
            r_entry[wb_id].value <= wb_value;
         end
         // Retirement is last so its valid clear wins over any same-entry update above.
         if (w_commit) begin
            r_entry[r_head].valid <= 1'b0;
            r_head                <= r_head + ID_ONE;
         end
         case ({w_alloc, w_commit})
            2'b10:   r_count <= r_count + CNT_ONE;
            2'b01:   r_count <= r_count - CNT_ONE;
            default: r_count <= r_count;
         endcase
      end
   end

   assign alloc_id     = r_tail;
   assign head         = r_head;
   assign tail         = r_tail;
   assign count        = r_count;
   assign commit_addr  = w_head_entry.addr;
   assign commit_value = w_head_entry.value;
   assign commit_we    = w_head_entry.we;

endmodule
